// File: rtl/l2_cache_assoc_ctrl.sv
// Set-associative write-back L2 cache: tag/data arrays, tree pseudo-LRU replacement and
// a single-outstanding-line controller between the L1 arbiter and physical memory.
module l2_cache_assoc_ctrl #(
  parameter int WAYS      = 4,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int CNT_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 l2cmem_read,
  input  logic                 l2cmem_write,
  input  logic [31:0]          l2cmem_address,
  input  logic [LINE_BITS-1:0] l2cmem_wdata,
  output logic [LINE_BITS-1:0] l2cmem_rdata,
  output logic                 l2cmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp,
  output logic [CNT_BITS-1:0]  hit_count,
  output logic [CNT_BITS-1:0]  miss_count,
  output logic [CNT_BITS-1:0]  wb_count
);

  localparam int OB    = $clog2(LINE_BITS / 8);
  localparam int IB    = $clog2(SETS);
  localparam int TB    = 32 - OB - IB;
  localparam int WB_W  = $clog2(WAYS);
  localparam int NODES = WAYS - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TAG  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_FILL = 2'd3;

  logic [1:0]               state;
  logic [31-OB:0]           line_q;
  logic [LINE_BITS-1:0]     wdata_q;
  logic                     op_write_q;
  logic                     retry_q;
  logic [WB_W-1:0]          victim_q;

  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0][WAYS-1:0]  dirty_q;
  logic [SETS-1:0][NODES-1:0] plru_q;
  logic [LINE_BITS-1:0]       data_arr [WAYS][SETS];
  logic [TB-1:0]              tag_arr  [WAYS][SETS];

  logic [IB-1:0]   idx;
  logic [TB-1:0]   tag;
  logic            hit;
  logic [WB_W-1:0] hit_way;
  logic [WB_W-1:0] victim_sel;
  logic            unused_offset;

  assign idx           = line_q[IB-1:0];
  assign tag           = line_q[31-OB:IB];
  assign unused_offset = ^l2cmem_address[OB-1:0];

  // Walk the tree from the root following each node bit (0 = left) down to a leaf.
  function automatic logic [WB_W-1:0] plru_victim(input logic [NODES-1:0] t);
    logic [WB_W-1:0] w;
    logic            dir;
    int              n;
    w = '0;
    n = 0;
    for (int l = 0; l < WB_W; l++) begin
      dir = 1'b0;
      for (int k = 0; k < NODES; k++)
        if (k == n) dir = t[k];
      w = (w << 1) | WB_W'(dir);
      n = 2 * n + 1 + int'(dir);
    end
    return w;
  endfunction

  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] t,
                                                  input logic [WB_W-1:0] way);
    logic [NODES-1:0] r;
    logic [WB_W-1:0]  sh;
    logic             dir;
    int               n;
    r = t;
    n = 0;
    for (int l = 0; l < WB_W; l++) begin
      sh  = way >> (WB_W - 1 - l);
      dir = sh[0];
      for (int k = 0; k < NODES; k++)
        if (k == n) r[k] = ~dir;
      n = 2 * n + 1 + int'(dir);
    end
    return r;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[idx][w] && (tag_arr[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WB_W'(w);
      end
  end

  // Lowest-index invalid way wins over the PLRU choice.
  always_comb begin
    victim_sel = plru_victim(plru_q[idx]);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim_sel = WB_W'(w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_write_q <= 1'b0;
      retry_q    <= 1'b0;
      victim_q   <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      plru_q     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (l2cmem_read || l2cmem_write) begin
            op_write_q <= l2cmem_write;
            retry_q    <= 1'b0;
            state      <= ST_TAG;
          end
        end
        ST_TAG: begin
          if (hit) begin
            plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            if (op_write_q) dirty_q[idx][hit_way] <= 1'b1;
            if (!retry_q) hit_count <= sat_inc(hit_count);
            retry_q <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            miss_count <= sat_inc(miss_count);
            victim_q   <= victim_sel;
            state      <= (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) ? ST_WB : ST_FILL;
          end
        end
        ST_WB: begin
          if (pmem_resp) begin
            wb_count <= sat_inc(wb_count);
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (pmem_resp) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            retry_q                <= 1'b1;
            state                  <= ST_TAG;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request capture and array contents carry no reset; valid bits guard the arrays.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && (l2cmem_read || l2cmem_write)) begin
      line_q  <= l2cmem_address[31:OB];
      wdata_q <= l2cmem_wdata;
    end
    if (state == ST_TAG && hit && op_write_q)
      data_arr[hit_way][idx] <= wdata_q;
    if (state == ST_FILL && pmem_resp) begin
      data_arr[victim_q][idx] <= pmem_rdata;
      tag_arr[victim_q][idx]  <= tag;
    end
  end

  always_comb begin
    l2cmem_resp  = (state == ST_TAG) && hit;
    l2cmem_rdata = (l2cmem_resp && !op_write_q) ? data_arr[hit_way][idx] : '0;
    pmem_write   = (state == ST_WB);
    pmem_read    = (state == ST_FILL);
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state == ST_WB) begin
      pmem_address = {tag_arr[victim_q][idx], idx, {OB{1'b0}}};
      pmem_wdata   = data_arr[victim_q][idx];
    end else if (state == ST_FILL) begin
      pmem_address = {tag, idx, {OB{1'b0}}};
    end
  end

endmodule

// File: tb/tb_l2_cache_assoc_ctrl.sv
// Bench for l2_cache_assoc_ctrl: directed scenarios plus random traffic checked against
// a line-address-level cache model with a range-descent PLRU tree and a sparse memory.
module tb_l2_cache_assoc_ctrl;
  localparam int WAYS   = 4;
  localparam int SETS   = 16;
  localparam int LB     = 256;
  localparam int CW     = 32;
  localparam int LBYTES = LB / 8;
  typedef logic [LB-1:0] line_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          l2cmem_read, l2cmem_write, l2cmem_resp;
  logic [31:0]   l2cmem_address, pmem_address;
  line_t         l2cmem_wdata, l2cmem_rdata, pmem_wdata, pmem_rdata;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  l2_cache_assoc_ctrl #(.WAYS(WAYS), .SETS(SETS), .LINE_BITS(LB), .CNT_BITS(CW)) dut (
    .clk(clk), .rst(rst),
    .l2cmem_read(l2cmem_read), .l2cmem_write(l2cmem_write), .l2cmem_address(l2cmem_address),
    .l2cmem_wdata(l2cmem_wdata), .l2cmem_rdata(l2cmem_rdata), .l2cmem_resp(l2cmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  logic        s_read, s_write, s_resp, s_pread, s_pwrite, s_presp;
  logic [31:0] s_addr, s_paddr;
  logic [63:0] s_wdata, s_rdata, s_pwdata, s_prdata;
  logic [1:0]  s_hit, s_miss, s_wbc;

  l2_cache_assoc_ctrl #(.WAYS(2), .SETS(2), .LINE_BITS(64), .CNT_BITS(2)) dut_s (
    .clk(clk), .rst(rst),
    .l2cmem_read(s_read), .l2cmem_write(s_write), .l2cmem_address(s_addr),
    .l2cmem_wdata(s_wdata), .l2cmem_rdata(s_rdata), .l2cmem_resp(s_resp),
    .pmem_read(s_pread), .pmem_write(s_pwrite), .pmem_address(s_paddr),
    .pmem_wdata(s_pwdata), .pmem_rdata(s_prdata), .pmem_resp(s_presp),
    .hit_count(s_hit), .miss_count(s_miss), .wb_count(s_wbc)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: each way remembers the full line address it holds.
  logic [31:0] m_la  [SETS][WAYS];
  bit          m_val [SETS][WAYS];
  bit          m_dty [SETS][WAYS];
  line_t       m_dat [SETS][WAYS];
  bit          m_tree[SETS][WAYS-1];
  int unsigned m_hit, m_miss, m_wb;
  line_t       mem [bit [31:0]];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_val[s][w] = 0;
        m_dty[s][w] = 0;
      end
      for (int n = 0; n < WAYS - 1; n++) m_tree[s][n] = 0;
    end
    m_hit = 0; m_miss = 0; m_wb = 0;
  endtask

  function automatic line_t mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {8{a ^ 32'h3c5a_0f00}};
  endfunction

  function automatic line_t rand_line();
    line_t r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int tree_victim(input int s);
    int node = 0;
    int lo = 0;
    int size = WAYS;
    while (size > 1) begin
      size = size / 2;
      if (m_tree[s][node]) begin
        lo = lo + size;
        node = 2 * node + 2;
      end else node = 2 * node + 1;
    end
    return lo;
  endfunction

  task automatic tree_touch(input int s, input int w);
    int node = 0;
    int lo = 0;
    int size = WAYS;
    while (size > 1) begin
      size = size / 2;
      if (w < lo + size) begin
        m_tree[s][node] = 1;
        node = 2 * node + 1;
      end else begin
        m_tree[s][node] = 0;
        lo = lo + size;
        node = 2 * node + 2;
      end
    end
  endtask

  task automatic model_access(input bit wr, input logic [31:0] addr, input line_t wd,
                              output bit hit, output bit wbf, output logic [31:0] wba,
                              output line_t wbd, output logic [31:0] fa, output line_t rd);
    logic [31:0] la;
    int s, w;
    la  = addr & ~32'(LBYTES - 1);
    s   = int'((la / LBYTES) % SETS);
    w   = -1;
    wbf = 0; wba = 0; wbd = '0; fa = 0;
    for (int i = 0; i < WAYS; i++)
      if (m_val[s][i] && m_la[s][i] == la) w = i;
    hit = (w >= 0);
    if (hit) m_hit++;
    else begin
      m_miss++;
      for (int i = WAYS - 1; i >= 0; i--)
        if (!m_val[s][i]) w = i;
      if (w < 0) w = tree_victim(s);
      if (m_val[s][w] && m_dty[s][w]) begin
        wbf = 1;
        wba = m_la[s][w];
        wbd = m_dat[s][w];
        mem[wba] = wbd;
        m_wb++;
      end
      fa = la;
      m_dat[s][w] = mem_rd(la);
      m_la[s][w]  = la;
      m_val[s][w] = 1;
      m_dty[s][w] = 0;
    end
    tree_touch(s, w);
    if (wr) begin
      m_dat[s][w] = wd;
      m_dty[s][w] = 1;
    end
    rd = m_dat[s][w];
  endtask

  logic [31:0] g_wb_a;
  line_t       g_wb_d;
  int          g_n_wb, g_n_fill;

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input line_t wd, input string nm);
    bit e_hit, e_wb, active, unstable, overlap;
    logic [31:0] e_wba, e_fa, cur_a, fill_a;
    line_t e_wbd, e_rd, got;
    int cyc, first_req, last_presp, resp_cyc, lat;
    model_access(wr, addr, wd, e_hit, e_wb, e_wba, e_wbd, e_fa, e_rd);
    l2cmem_read = rd; l2cmem_write = wr; l2cmem_address = addr; l2cmem_wdata = wd;
    cyc = 0; first_req = -1; last_presp = -1; resp_cyc = -1; lat = 0;
    active = 0; unstable = 0; overlap = 0; cur_a = 0; fill_a = 0; got = '0;
    g_n_wb = 0; g_n_fill = 0; g_wb_a = 0; g_wb_d = '0;
    while (resp_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      pmem_resp = 0;
      pmem_rdata = rand_line();
      if (pmem_read && pmem_write) overlap = 1;
      if (l2cmem_resp) begin
        resp_cyc = cyc;
        got = l2cmem_rdata;
        l2cmem_read = 0;
        l2cmem_write = 0;
      end else if (pmem_read || pmem_write) begin
        if (!active) begin
          active = 1;
          cur_a = pmem_address;
          lat = $urandom_range(0, 3);
          if (first_req < 0) first_req = cyc;
          if (pmem_write) begin
            g_n_wb++; g_wb_a = pmem_address; g_wb_d = pmem_wdata;
          end else begin
            g_n_fill++; fill_a = pmem_address;
          end
        end else if (pmem_address !== cur_a) unstable = 1;
        if (lat == 0) begin
          pmem_resp = 1;
          if (pmem_read) pmem_rdata = mem_rd(pmem_address);
          last_presp = cyc;
          active = 0;
        end else lat--;
      end
    end
    l2cmem_read = 0; l2cmem_write = 0; pmem_resp = 0;
    check({nm, "/done"}, resp_cyc >= 0, 1);
    check({nm, "/nwb"}, g_n_wb, int'(e_wb));
    check({nm, "/nfill"}, g_n_fill, e_hit ? 0 : 1);
    if (e_hit) check({nm, "/hitlat"}, resp_cyc, 1);
    else begin
      check({nm, "/reqlat"}, first_req, 2);
      check({nm, "/filla"}, fill_a, e_fa);
      check({nm, "/resplat"}, resp_cyc, last_presp + 1);
    end
    if (e_wb) begin
      check({nm, "/wba"}, g_wb_a, e_wba);
      check({nm, "/wbd"}, g_wb_d, e_wbd);
    end
    if (!wr) check({nm, "/rdata"}, got, e_rd);
    check({nm, "/overlap"}, overlap, 0);
    check({nm, "/stable"}, unstable, 0);
    @(negedge clk);
    check({nm, "/pulse"}, l2cmem_resp, 0);
    check({nm, "/idle"}, {pmem_read, pmem_write}, 0);
    check({nm, "/hitcnt"}, hit_count, m_hit);
    check({nm, "/misscnt"}, miss_count, m_miss);
    check({nm, "/wbcnt"}, wb_count, m_wb);
  endtask

  task automatic do_reset();
    rst = 1; l2cmem_read = 0; l2cmem_write = 0; pmem_resp = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    int n, cyc, r;
    bit seen;
    logic [31:0] a;
    l2cmem_read = 0; l2cmem_write = 0; l2cmem_address = 0; l2cmem_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
    s_read = 0; s_write = 0; s_addr = 0; s_wdata = '0; s_presp = 0; s_prdata = '0;
    repeat (3) @(negedge clk);
    check("rst/resp", l2cmem_resp, 0);
    check("rst/rdata", l2cmem_rdata, 0);
    check("rst/pmem_rw", {pmem_read, pmem_write}, 0);
    check("rst/paddr", pmem_address, 0);
    check("rst/counters", {hit_count, miss_count, wb_count}, 0);
    rst = 0;
    model_reset();

    mem[32'h40] = {32{8'hA5}};
    do_access(1, 0, 32'h0000_0040, '0, "cold");
    do_access(1, 0, 32'h0000_0040, '0, "rehit");

    for (int i = 0; i < 4; i++)
      do_access(0, 1, 32'(i) * 32'h200, {8{32'h1111_0000 + 32'(i)}}, "fillwr");
    do_access(1, 0, 32'h0000_0800, '0, "evict");
    check("evict/addr0", g_wb_a, 32'h0000_0000);
    check("evict/line0", g_wb_d, {8{32'h1111_0000}});

    do_reset();
    for (int i = 0; i < 4; i++)
      do_access(0, 1, 32'(i) * 32'h200, rand_line(), "plrufill");
    do_access(1, 0, 32'h0000_0000, '0, "plru_w0");
    do_access(1, 0, 32'h0000_0400, '0, "plru_w2");
    do_access(1, 0, 32'h0000_0800, '0, "plru_miss");
    check("plru/victim_way1", g_wb_a, 32'h0000_0200);

    // Abort an outstanding fill with reset, then feed a stray pmem_resp while idle.
    l2cmem_read = 1; l2cmem_address = 32'h0000_0C40;
    seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (pmem_read) seen = 1;
    end
    check("midfill/seen", seen, 1);
    rst = 1; l2cmem_read = 0;
    @(negedge clk);
    check("midfill/pmem_rw", {pmem_read, pmem_write}, 0);
    check("midfill/resp", l2cmem_resp, 0);
    check("midfill/counters", {hit_count, miss_count, wb_count}, 0);
    rst = 0;
    model_reset();
    pmem_resp = 1; pmem_rdata = rand_line();
    @(negedge clk);
    pmem_resp = 0;
    @(negedge clk);
    check("late/pmem_rw", {pmem_read, pmem_write}, 0);
    check("late/resp", l2cmem_resp, 0);
    do_access(1, 0, 32'h0000_0C40, '0, "remiss");
    check("remiss/fill", g_n_fill, 1);

    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 3)) << 5) |
          32'($urandom_range(0, 31));
      r = $urandom_range(0, 3);
      do_access(r != 0, r <= 1, a, rand_line(), "rand");
    end

    // Narrow counters: a held read gives one miss then back-to-back hits.
    s_read = 1; s_addr = 32'h0; n = 0; cyc = 0;
    while (n < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      s_presp = 0;
      if (s_resp) n++;
      else if (s_pread) begin
        s_presp = 1;
        s_prdata = 64'h0123_4567_89ab_cdef;
      end
    end
    s_read = 0; s_presp = 0;
    @(negedge clk);
    check("sat/resps", n, 6);
    check("sat/hit", s_hit, 2'd3);
    check("sat/miss", s_miss, 2'd1);
    check("sat/wb", s_wbc, 2'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
